// File: rtl/hazard_unit_if.sv
// Data-memory request/acknowledge handshake between the hazard unit and the data memory.
// The hazard unit holds data_req until the memory returns data_ok for the M-stage access.
interface hazard_unit_if;
   logic data_req;
   logic data_ok;

   modport master (
      output data_req,
      input  data_ok
   );

   modport slave (
      input  data_req,
      output data_ok
   );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch stalls, data-memory wait FSM and
// multi-cycle divide wait counter. Define STALL_PERF_CNT_EN to enable the stall counters.
module hazard_unit #(
   parameter int unsigned DIV_CYCLES = 36,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rsD,
   input  logic [4:0]       rtD,
   input  logic [4:0]       rsE,
   input  logic [4:0]       rtE,
   input  logic [4:0]       writeregE,
   input  logic [4:0]       writeregM,
   input  logic [4:0]       writeregW,
   input  logic             regwriteE,
   input  logic             regwriteM,
   input  logic             regwriteW,
   input  logic [3:0]       memtoregE,
   input  logic [3:0]       memtoregM,
   input  logic [3:0]       memwriteM,
   input  logic             branchD,
   input  logic             jrD,
   input  logic             divE,
   input  logic             excM,
   hazard_unit_if.master    memBus,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             stallW,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             div_done,
   output logic [CNT_W-1:0] perf_lw,
   output logic [CNT_W-1:0] perf_div,
   output logic [CNT_W-1:0] perf_mem
);

   localparam int unsigned CntBits = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StMem, StDiv} stateT;

   stateT              stateQ, stateD;
   logic [CntBits-1:0] divCntQ, divCntD;
   logic               doneQ, doneD;

   logic access, dataReqNow, memBusy, inDiv, divLast, divStart, divHold;
   logic lwStall, brStall;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   function automatic logic regHit(input logic en, input logic [4:0] dst, input logic [4:0] src);
      return en && (dst != 5'd0) && (dst == src);
   endfunction

   always_comb begin
      forwardAD = regHit(regwriteM, writeregM, rsD);
      forwardBD = regHit(regwriteM, writeregM, rtD);
      if (regHit(regwriteM, writeregM, rsE)) begin
         forwardAE = 2'b10;
      end else if (regHit(regwriteW, writeregW, rsE)) begin
         forwardAE = 2'b01;
      end else begin
         forwardAE = 2'b00;
      end
      if (regHit(regwriteM, writeregM, rtE)) begin
         forwardBE = 2'b10;
      end else if (regHit(regwriteW, writeregW, rtE)) begin
         forwardBE = 2'b01;
      end else begin
         forwardBE = 2'b00;
      end
   end

   assign lwStall = (memtoregE != 4'd0) && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
   assign brStall = (branchD || jrD) &&
                    (regHit(regwriteE, writeregE, rsD) || regHit(regwriteE, writeregE, rtD) ||
                     regHit(memtoregM != 4'd0, writeregM, rsD) ||
                     regHit(memtoregM != 4'd0, writeregM, rtD));

   assign access     = (memtoregM | memwriteM) != 4'd0;
   assign inDiv      = (stateQ == StDiv);
   // M is bubbled while a divide runs, so no access is started from DIV.
   assign dataReqNow = !excM && ((stateQ == StMem) || ((stateQ == StIdle) && access));
   assign memBusy    = dataReqNow && !memBus.data_ok;
   assign divLast    = inDiv && (divCntQ == CntBits'(1));
   assign divStart   = !excM && !inDiv && !memBusy && divE && !doneQ;
   assign divHold    = !excM && (divStart || (inDiv && !divLast));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ  <= StIdle;
         divCntQ <= '0;
         doneQ   <= 1'b0;
      end else begin
         stateQ  <= stateD;
         divCntQ <= divCntD;
         doneQ   <= doneD;
      end
   end

   always_comb begin
      stateD  = stateQ;
      divCntD = divCntQ;
      doneD   = doneQ;
      if (excM) begin
         stateD  = StIdle;
         divCntD = '0;
         doneD   = 1'b0;
      end else begin
         unique case (stateQ)
            StIdle, StMem: begin
               if (memBusy) begin
                  stateD = StMem;
               end else if (divStart) begin
                  stateD  = StDiv;
                  divCntD = CntBits'(DIV_CYCLES - 1);
               end else begin
                  stateD = StIdle;
               end
            end
            StDiv: begin
               divCntD = divCntQ - CntBits'(1);
               if (divLast) begin
                  stateD = StIdle;
               end
            end
            default: stateD = StIdle;
         endcase
         // Blocks a second done pulse while the finished divide may still sit in E.
         if (div_done) begin
            doneD = 1'b1;
         end else if (!stallE) begin
            doneD = 1'b0;
         end
      end
   end

   always_comb begin
      stallF          = 1'b0;
      stallD          = 1'b0;
      stallE          = 1'b0;
      stallM          = 1'b0;
      stallW          = 1'b0;
      flushD          = 1'b0;
      flushE          = 1'b0;
      flushM          = 1'b0;
      flushW          = 1'b0;
      memBus.data_req = dataReqNow;
      div_done        = divLast && !excM;
      if (excM) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else if (memBusy) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (divHold) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         flushM = 1'b1;
      end else if (lwStall || brStall) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] perfLwQ, perfDivQ, perfMemQ;
   logic             lwBrSel, divSel;

   assign lwBrSel = !excM && !memBusy && !divHold && (lwStall || brStall);
   assign divSel  = !excM && (divStart || inDiv);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perfLwQ  <= '0;
         perfDivQ <= '0;
         perfMemQ <= '0;
      end else begin
         if (lwBrSel && (perfLwQ != '1)) begin
            perfLwQ <= perfLwQ + CNT_W'(1);
         end
         if (divSel && (perfDivQ != '1)) begin
            perfDivQ <= perfDivQ + CNT_W'(1);
         end
         if (memBusy && (perfMemQ != '1)) begin
            perfMemQ <= perfMemQ + CNT_W'(1);
         end
      end
   end

   assign perf_lw  = perfLwQ;
   assign perf_div = perfDivQ;
   assign perf_mem = perfMemQ;
`else
   assign perf_lw  = '0;
   assign perf_div = '0;
   assign perf_mem = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic checked
// cycle by cycle against a behavioural model of the stall/flush/forward rules.
module tb_hazard_unit;
   localparam int unsigned DivCycles = 4;
   localparam int unsigned CntW      = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic       regwriteE, regwriteM, regwriteW;
   logic [3:0] memtoregE, memtoregM, memwriteM;
   logic       branchD, jrD, divE, excM;
   logic       forwardAD, forwardBD;
   logic [1:0] forwardAE, forwardBE;
   logic       stallF, stallD, stallE, stallM, stallW;
   logic       flushD, flushE, flushM, flushW;
   logic       div_done;
   logic [CntW-1:0] perf_lw, perf_div, perf_mem;

   hazard_unit_if memBus();

   hazard_unit #(
      .DIV_CYCLES(DivCycles),
      .CNT_W     (CntW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rsD      (rsD),
      .rtD      (rtD),
      .rsE      (rsE),
      .rtE      (rtE),
      .writeregE(writeregE),
      .writeregM(writeregM),
      .writeregW(writeregW),
      .regwriteE(regwriteE),
      .regwriteM(regwriteM),
      .regwriteW(regwriteW),
      .memtoregE(memtoregE),
      .memtoregM(memtoregM),
      .memwriteM(memwriteM),
      .branchD  (branchD),
      .jrD      (jrD),
      .divE     (divE),
      .excM     (excM),
      .memBus   (memBus),
      .forwardAD(forwardAD),
      .forwardBD(forwardBD),
      .forwardAE(forwardAE),
      .forwardBE(forwardBE),
      .stallF   (stallF),
      .stallD   (stallD),
      .stallE   (stallE),
      .stallM   (stallM),
      .stallW   (stallW),
      .flushD   (flushD),
      .flushE   (flushE),
      .flushM   (flushM),
      .flushW   (flushW),
      .div_done (div_done),
      .perf_lw  (perf_lw),
      .perf_div (perf_div),
      .perf_mem (perf_mem)
   );

   int total = 0;
   int bad   = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model state: outstanding memory wait, divide cycles still to run, done-pulse guard.
   bit     mMemWait;
   int     mDivLeft;
   bit     mJustDone;
   longint mPerfLw, mPerfDiv, mPerfMem;
   longint maxCnt = (longint'(1) << CntW) - 1;

   task automatic modelReset();
      mMemWait  = 0;
      mDivLeft  = 0;
      mJustDone = 0;
      mPerfLw   = 0;
      mPerfDiv  = 0;
      mPerfMem  = 0;
   endtask

   function automatic bit dep(input bit en, input logic [4:0] dst, input logic [4:0] src);
      return en && dst != 0 && dst == src;
   endfunction

   function automatic logic [1:0] fwdSel(input logic [4:0] src);
      if (dep(regwriteM, writeregM, src)) return 2'b10;
      if (dep(regwriteW, writeregW, src)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic modelCycle();
      bit access, dividing, reqNow, busy, startDiv, finishing, holdDiv, lw, br;
      logic [4:0] eStall;
      logic [3:0] eFlush;
      bit eReq, eDone;
`ifdef STALL_PERF_CNT_EN
      checkVal("perfLw", perf_lw, 64'(mPerfLw));
      checkVal("perfDiv", perf_div, 64'(mPerfDiv));
      checkVal("perfMem", perf_mem, 64'(mPerfMem));
`else
      checkVal("perfAll", {perf_lw, perf_div, perf_mem}, 0);
`endif
      access = (memtoregM != 0) || (memwriteM != 0);
      lw = memtoregE != 0 && rtE != 0 && (rtE == rsD || rtE == rtD);
      br = (branchD || jrD) && (dep(regwriteE, writeregE, rsD) || dep(regwriteE, writeregE, rtD)
           || dep(memtoregM != 0, writeregM, rsD) || dep(memtoregM != 0, writeregM, rtD));
      eStall = '0;
      eFlush = '0;
      eReq   = 0;
      eDone  = 0;
      if (excM) begin
         eFlush    = 4'hF;
         mMemWait  = 0;
         mDivLeft  = 0;
         mJustDone = 0;
      end else begin
         dividing  = mDivLeft > 0;
         reqNow    = mMemWait || (!dividing && access);
         busy      = reqNow && !memBus.data_ok;
         startDiv  = !dividing && !busy && divE && !mJustDone;
         finishing = dividing && mDivLeft == 1;
         holdDiv   = startDiv || (dividing && !finishing);
         eReq      = reqNow;
         eDone     = finishing;
         if (busy) begin
            eStall = 5'b11110;
            eFlush = 4'b0001;
         end else if (holdDiv) begin
            eStall = 5'b11100;
            eFlush = 4'b0010;
         end else if (lw || br) begin
            eStall = 5'b11000;
            eFlush = 4'b0100;
            if (mPerfLw < maxCnt) mPerfLw++;
         end
         if ((startDiv || dividing) && mPerfDiv < maxCnt) mPerfDiv++;
         if (busy && mPerfMem < maxCnt) mPerfMem++;
         mJustDone = finishing || (mJustDone && eStall[2]);
         mMemWait  = busy;
         mDivLeft  = startDiv ? int'(DivCycles) - 1 : (dividing ? mDivLeft - 1 : 0);
      end
      checkVal("fwdE", {forwardAE, forwardBE}, {fwdSel(rsE), fwdSel(rtE)});
      checkVal("fwdD", {forwardAD, forwardBD},
               {dep(regwriteM, writeregM, rsD), dep(regwriteM, writeregM, rtD)});
      checkVal("stall", {stallF, stallD, stallE, stallM, stallW}, eStall);
      checkVal("flush", {flushD, flushE, flushM, flushW}, eFlush);
      checkVal("dataReq", memBus.data_req, eReq);
      checkVal("divDone", div_done, eDone);
   endtask

   // Called at a negedge with inputs driven; checks, clocks, optionally pulses reset.
   task automatic stepCycle(input bit doRst = 0);
      #2;
      modelCycle();
      @(posedge clk);
      if (doRst) begin
         #1 rst = 1'b0;
         #1 rst = 1'b1;
         modelReset();
      end
      @(negedge clk);
   endtask

   task automatic clearInputs();
      {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
      {regwriteE, regwriteM, regwriteW} = '0;
      {memtoregE, memtoregM, memwriteM} = '0;
      {branchD, jrD, divE, excM} = '0;
      memBus.data_ok = 1'b0;
   endtask

   task automatic randomInputs();
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      memtoregM = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      memwriteM = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      branchD   = ($urandom_range(0, 4) == 0);
      jrD       = ($urandom_range(0, 9) == 0);
      divE      = ($urandom_range(0, 11) == 0);
      excM      = ($urandom_range(0, 39) == 0);
      memBus.data_ok = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int nStallE, nDone, doneAt, nReq, nStallM, nFlushW;
      clearInputs();
      modelReset();
      @(negedge clk);
      #2;
      checkVal("rstStall", {stallF, stallD, stallE, stallM, stallW}, 0);
      checkVal("rstFlush", {flushD, flushE, flushM, flushW}, 0);
      checkVal("rstMisc", {memBus.data_req, div_done, forwardAE, forwardBE}, 0);
      checkVal("rstPerf", {perf_lw, perf_div, perf_mem}, 0);
      rst = 1'b1;
      @(negedge clk);

      // Forwarding, including the register-0 exclusion.
      regwriteM = 1'b1; writeregM = 5'd3; rsE = 5'd3;
      regwriteW = 1'b1; writeregW = 5'd7; rtE = 5'd7;
      #1;
      checkVal("fwdAEfromM", forwardAE, 2'b10);
      checkVal("fwdBEfromW", forwardBE, 2'b01);
      stepCycle();
      writeregM = 5'd0; rsE = 5'd0;
      #1;
      checkVal("fwdReg0", forwardAE, 2'b00);
      stepCycle();

      // Load-use stall lasts exactly one cycle, then W forwarding resolves it.
      clearInputs();
      memtoregE = 4'hF; rtE = 5'd2; rsD = 5'd2;
      #1;
      checkVal("lwStall", {stallF, stallD, flushE, stallE}, 4'b1110);
      stepCycle();
      clearInputs();
      rsD = 5'd2;
      #1;
      checkVal("lwStallGone", {stallF, stallD, flushE}, 3'b000);
      stepCycle();
      clearInputs();
      rsE = 5'd2; regwriteW = 1'b1; writeregW = 5'd2;
      #1;
      checkVal("lwFwdW", forwardAE, 2'b01);
      stepCycle();

      // Divide occupies E for DivCycles cycles with a single done pulse on the last.
      clearInputs();
      divE = 1'b1;
      nStallE = 0; nDone = 0; doneAt = -1;
      for (int i = 0; i < int'(DivCycles); i++) begin
         #1;
         if (stallE) nStallE++;
         if (div_done) begin nDone++; doneAt = i; end
         stepCycle();
      end
      divE = 1'b0;
      checkVal("divStallE", nStallE, DivCycles - 1);
      checkVal("divDoneCnt", nDone, 1);
      checkVal("divDoneAt", doneAt, DivCycles - 1);
      stepCycle();

      // Store waiting three cycles for its acknowledge.
      clearInputs();
      memwriteM = 4'b0001;
      nReq = 0; nStallM = 0; nFlushW = 0;
      for (int i = 0; i < 4; i++) begin
         memBus.data_ok = (i == 3);
         #1;
         if (memBus.data_req) nReq++;
         if (stallM) nStallM++;
         if (flushW) nFlushW++;
         stepCycle();
      end
      clearInputs();
      checkVal("memReq", nReq, 4);
      checkVal("memStallM", nStallM, 3);
      checkVal("memFlushW", nFlushW, 3);
      stepCycle();

      // Exception in the middle of a divide.
      divE = 1'b1;
      stepCycle();
      stepCycle();
      excM = 1'b1;
      #1;
      checkVal("excFlush", {flushD, flushE, flushM, flushW}, 4'hF);
      checkVal("excStall", {stallF, stallD, stallE, stallM, stallW, memBus.data_req}, 0);
      checkVal("excDone", div_done, 1'b0);
      stepCycle();
      clearInputs();
      nDone = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (div_done) nDone++;
         stepCycle();
      end
      checkVal("excNoDone", nDone, 0);

`ifdef STALL_PERF_CNT_EN
      rst = 1'b0;
      #1 rst = 1'b1;
      modelReset();
      for (int k = 0; k < 2; k++) begin
         clearInputs();
         memtoregE = 4'h1; rtE = 5'd5; rsD = 5'd5;
         stepCycle();
         clearInputs();
         stepCycle();
      end
      divE = 1'b1;
      for (int i = 0; i < int'(DivCycles); i++) stepCycle();
      clearInputs();
      #1;
      checkVal("perfLwDirected", perf_lw, 2);
      checkVal("perfDivDirected", perf_div, DivCycles);
`endif

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 3000; n++) begin
         randomInputs();
         stepCycle($urandom_range(0, 149) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
